// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and types for the conv layer chain
package conv_pkg;

    localparam int DATA_W     = 32;
    localparam int FMAP_DIM   = 12;
    localparam int KERNEL_DIM = 3;
    localparam int OUT_DIM    = FMAP_DIM - KERNEL_DIM + 1;

    localparam logic [DATA_W-1:0] FX_ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } coll_state_t;

endpackage

// File: rtl/fmap_buffer.sv
// rtl/fmap_buffer.sv - simple dual-port feature map RAM, one write port, one synchronous read port
module fmap_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register doubles as the replay output, so it holds when rd_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv_out_collector.sv
// rtl/conv_out_collector.sv - captures a conv result map and replays it as a valid/ready stream
// Optional CONV_COLLECT_RELU_EN: negative words are stored as 0 at write time.
module conv_out_collector #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int DEPTH  = conv_pkg::OUT_DIM * conv_pkg::OUT_DIM,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_invalid,
    input  logic              in_finish,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    import conv_pkg::*;

    coll_state_t       state;
    logic [CNT_W-1:0]  rd;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic              in_word;
    logic              at_full;
    logic              wr_en;
    logic              rd_en;
    logic              xfer;

    assign in_word   = !in_invalid;
    assign count_inc = count + 1'b1;
    assign at_full   = (count == CNT_W'(DEPTH));
    assign wr_en     = in_word && (state != ST_DRAIN) && !at_full;
    assign xfer      = out_valid && out_ready;
    assign busy      = (state != ST_IDLE);

`ifdef CONV_COLLECT_RELU_EN
    assign wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign wr_data = in_data;
`endif

    // First DRAIN cycle fetches word 0; every later transfer prefetches rd+1.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state == ST_DRAIN) begin
            if (!out_valid) begin
                rd_en = 1'b1;
            end else if (xfer && !out_last) begin
                rd_en   = 1'b1;
                rd_addr = rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            rd        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_word && !wr_en) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_CAPTURE: begin
                    if (wr_en) begin
                        count <= count_inc;
                        state <= (in_finish || count_inc == CNT_W'(DEPTH)) ? ST_DRAIN : ST_CAPTURE;
                    end else if (in_finish && count != '0) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_last  <= (count == CNT_W'(1));
                    end else if (xfer) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            count     <= '0;
                            rd        <= '0;
                        end else begin
                            rd       <= rd + 1'b1;
                            out_last <= ((rd + CNT_W'(2)) == count);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fmap_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (CNT_W)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (count),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_conv_out_collector.sv
// tb/tb_conv_out_collector.sv - directed self-checking bench for conv_out_collector
module tb_conv_out_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 100;
    localparam int CW    = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_invalid;
    logic          in_finish;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] cap_q[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    conv_out_collector dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_invalid (in_invalid),
        .in_finish  (in_finish),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .count      (count),
        .overflow   (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp(input int n, input int base);
        cap_q.delete();
        for (int i = 0; i < n; i++) cap_q.push_back(DW'(base + i));
        exp_q = cap_q;
    endtask

    task automatic capture(input bit fin_last);
        for (int i = 0; i < cap_q.size(); i++) begin
            in_invalid = 1'b0;
            in_data    = cap_q[i];
            in_finish  = fin_last && (i == cap_q.size() - 1);
            tick;
            total++;
            if (count !== CW'(i + 1)) begin
                bad++;
                $display("FAIL capture_count word %0d: got %0d want %0d", i, count, i + 1);
            end
        end
        in_invalid = 1'b1;
        in_finish  = 1'b0;
    endtask

    task automatic run_drain(input int n, input bit stall, input bit started);
        int k   = 0;
        int cyc = 0;
        bit r;
        if (!started) begin
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL drain_entry: valid=%b busy=%b want valid=0 busy=1", out_valid, busy);
            end
            out_ready = 1'b1;
            tick;
        end
        while (k < n && cyc < 1000) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k == n - 1) || busy !== 1'b1) begin
                bad++;
                $display("FAIL drain_word %0d: valid=%b data=%h last=%b busy=%b want valid=1 data=%h last=%b busy=1",
                         k, out_valid, out_data, out_last, busy, exp_q[k], (k == n - 1));
            end
            r = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            out_ready = r;
            tick;
            cyc++;
            if (r) k++;
        end
        total++;
        if (k != n || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || count !== '0) begin
            bad++;
            $display("FAIL drain_end: words=%0d busy=%b valid=%b last=%b count=%0d want words=%0d busy=0 valid=0 last=0 count=0",
                     k, busy, out_valid, out_last, count, n);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_invalid = 1'b1; in_finish = 1'b0; in_data = '0; out_ready = 1'b1;
        tick;
        tick;
        total++;
        if (out_data !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: data=%h valid=%b last=%b busy=%b count=%0d ovf=%b want all 0",
                     out_data, out_valid, out_last, busy, count, overflow);
        end
        reset = 1'b0;
        in_finish = 1'b1;
        tick;
        in_finish = 1'b0;
        tick;
        total++;
        if (busy !== 1'b0 || count !== '0) begin
            bad++;
            $display("FAIL idle_finish_ignored: busy=%b count=%0d want busy=0 count=0", busy, count);
        end
    endtask

    task automatic test_full_map;
        fill_ramp(100, 0);
        capture(1'b0);
        total++;
        if (busy !== 1'b1 || count !== CW'(100)) begin
            bad++;
            $display("FAIL full_entry: busy=%b count=%0d want busy=1 count=100", busy, count);
        end
        run_drain(100, 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_partial;
        fill_ramp(40, 32'hA000);
        capture(1'b0);
        in_finish = 1'b1;
        tick;
        in_finish = 1'b0;
        total++;
        if (count !== CW'(40) || busy !== 1'b1) begin
            bad++;
            $display("FAIL partial_count: count=%0d busy=%b want count=40 busy=1", count, busy);
        end
        run_drain(40, 1'b0, 1'b0);
        fill_ramp(3, 32'h0B00);
        capture(1'b1);
        run_drain(3, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        fill_ramp(7, 32'h1234_0000);
        capture(1'b1);
        run_drain(7, 1'b1, 1'b0);
    endtask

    task automatic test_relu;
        cap_q.delete();
        cap_q.push_back(32'hFFFF_0000);
        cap_q.push_back(32'h0001_0000);
        exp_q.delete();
`ifdef CONV_COLLECT_RELU_EN
        exp_q.push_back(32'h0000_0000);
`else
        exp_q.push_back(32'hFFFF_0000);
`endif
        exp_q.push_back(32'h0001_0000);
        capture(1'b0);
        in_finish = 1'b1;
        tick;
        in_finish = 1'b0;
        run_drain(2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        fill_ramp(1, 32'h55);
        capture(1'b1);
        run_drain(1, 1'b0, 1'b0);
        fill_ramp(2, 32'h77);
        capture(1'b1);
        run_drain(2, 1'b1, 1'b0);
    endtask

    task automatic test_overflow;
        fill_ramp(100, 32'h200);
        capture(1'b0);
        out_ready  = 1'b0;
        in_invalid = 1'b0;
        in_data    = 32'h2064;
        tick;
        in_data    = 32'h2065;
        tick;
        in_invalid = 1'b1;
        total++;
        if (overflow !== 1'b1 || count !== CW'(100) || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set: ovf=%b count=%0d valid=%b want ovf=1 count=100 valid=1", overflow, count, out_valid);
        end
        run_drain(100, 1'b0, 1'b1);
        fill_ramp(2, 32'h7);
        capture(1'b1);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky: got %b want 1", overflow);
        end
        run_drain(2, 1'b0, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_reset: got %b want 0", overflow);
        end
    endtask

    task automatic test_reset_abort;
        fill_ramp(50, 32'h300);
        capture(1'b0);
        reset = 1'b1; in_invalid = 1'b0; in_data = 32'h332;
        tick;
        reset = 1'b0; in_invalid = 1'b1;
        total++;
        if (busy !== 1'b0 || count !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_capture: busy=%b count=%0d valid=%b want 0 0 0", busy, count, out_valid);
        end
        fill_ramp(100, 500);
        capture(1'b0);
        out_ready = 1'b1;
        repeat (4) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || count !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL abort_drain: busy=%b count=%0d valid=%b last=%b data=%h want all 0",
                     busy, count, out_valid, out_last, out_data);
        end
        fill_ramp(100, 1000);
        capture(1'b0);
        run_drain(100, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_full_map;
        test_partial;
        test_stall;
        test_relu;
        test_back_to_back;
        test_overflow;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_out_collector.md
# conv_out_collector

Captures the result stream of `conv_12x12` (one 32-bit Q16.16 word per cycle, qualified by active-low `invalid`) into an on-chip buffer. Once the feature map is complete it replays it to the next layer over a valid/ready stream. It sits directly behind the convolution engine and replaces file-dump capture for multi-layer chaining.

## Interface
Parameters:
- `DATA_W`, 32, word width (Q16.16 fixed point)
- `DEPTH`, 100, buffer words (10x10 output of a 3x3 kernel on a 12x12 map)
- `CNT_W`, `$clog2(DEPTH+1)`, width of `count`

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the next edge
- `in_data`  in  DATA_W  conv result word (`output_port`)
- `in_invalid`  in  1  low = `in_data` valid this cycle
- `in_finish`  in  1  conv end-of-map pulse
- `out_data`  out  DATA_W  replayed word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts word
- `out_last`  out  1  qualifies final word of map
- `busy`  out  1  state != IDLE
- `count`  out  CNT_W  words held
- `overflow`  out  1  sticky: word dropped; cleared only by reset

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `in_invalid`=0 writes `in_data` to `mem[0]`, sets `count`=1 and moves to CAPTURE.
  - `in_finish` alone is ignored.
- CAPTURE:
  - Each cycle with `in_invalid`=0 writes `mem[count]` and increments `count`.
  - Go to DRAIN when `count` reaches DEPTH, or on `in_finish` with `count`>0.
  - `in_finish` and a valid word in the same cycle: capture the word first, then transition.
- Full: a valid word arriving when `count`==DEPTH is dropped and sets `overflow`.
- DRAIN:
  - Read pointer `rd` starts at 0.
  - A word transfers on `out_valid && out_ready`.
  - `out_last`=1 when `rd`==`count`-1.
  - After the last transfer: return to IDLE and clear `count` and `rd`.
  - Any valid input word during DRAIN is dropped and sets `overflow`.
- `out_data` holds stable while `out_valid && !out_ready`.
- Reset mid-operation: abort. State returns to IDLE and all counters clear; buffer contents are don't-care.
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `count`=0, `overflow`=0.

## Timing
- Capture: the word is written on the same edge it is sampled; 1 word/cycle, no backpressure on the input side.
- DRAIN is entered on the edge that captures the final word (or samples `in_finish`).
- The buffer uses a synchronous read, so `out_valid` first rises one edge after entering DRAIN.
- Prefetch: on each transfer, `mem[rd+1]` is read so `out_data` updates on the next edge with no bubble.
- With `out_ready` held high, DEPTH words leave in DEPTH consecutive cycles.
- `out_valid`, `out_last` and `busy` fall on the edge of the last transfer; a new capture may start on the following cycle.

## Configuration
- `CONV_COLLECT_RELU_EN`
  - Defined: captured words with bit `DATA_W-1` set are stored as 0 (ReLU applied at write time; no added latency).
  - Undefined: words are stored unmodified.
- `count`, `overflow` and all timing are identical in both builds.

## Structure
- Shared package `conv_pkg`: `DATA_W`, `FMAP_DIM`=12, `KERNEL_DIM`=3, `OUT_DIM`=`FMAP_DIM-KERNEL_DIM+1`, the collector state enum, and the Q16.16 constant `FX_ONE`=32'h00010000.
- One sub-module, `fmap_buffer`: simple dual-port RAM, DEPTH x DATA_W, one write port, one synchronous read port.
- FSM, counters and ReLU live in the top module.

## Test plan
- 100 consecutive words 0..99 with `in_invalid`=0 and `out_ready`=1: DRAIN entered after word 99; `out_data` replays 0..99 in 100 consecutive cycles; `out_last` only on 99; `overflow`=0.
- 40 words, then an `in_finish` pulse: `count`=40; exactly 40 words replayed; `out_last` on the 40th word.
- 102 valid words: first 100 stored; `overflow`=1 and stays 1 through DRAIN and the next capture until reset.
- DRAIN with `out_ready` toggling 1,0,0,1: `out_data` and `out_valid` stable while stalled; no word duplicated or lost.
- Input 32'hFFFF0000 (-1.0) then 32'h00010000: with `CONV_COLLECT_RELU_EN` replays 0, 32'h00010000; without it replays the inputs unchanged.
- `reset` asserted at word 50 of CAPTURE and again mid-DRAIN: next edge shows IDLE, `busy`=0, `count`=0, `out_valid`=0; a fresh 100-word capture then completes correctly.
